sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the GPU SRAM arbiter. It accepts single-word (32-bit) and burst (16-bit stream) requests on the arbiter's `sram_*` interface and drives a 16-bit asynchronous SRAM. It returns read data, burst strobes and a completion `ack`, and honours burst cancellation so that the display port can preempt lower-priority ports.

## Interface
**Parameters**
- `ADDR_W`, default 24: SRAM halfword address width; all addresses wrap modulo 2^ADDR_W.

**Ports**
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  1: request; the arbiter holds it high until `ack`.
- `we`  in  1: 1 = write, 0 = read.
- `addr`  in  ADDR_W: start halfword address.
- `wdata`  in  32: single-word write data; `[15:0]` goes to `addr`, `[31:16]` to `addr+1`.
- `burst_len`  in  8: 0 = single 32-bit word; N>0 = burst of N halfwords.
- `burst_wdata`  in  16: show-ahead burst write word.
- `burst_cancel`  in  1: one-cycle preempt pulse.
- `rdata`  out  32: single-word read data, valid while `ack`=1.
- `ack`  out  1: one-cycle completion pulse.
- `ready`  out  1: controller is idle and will accept `req`.
- `burst_data_valid`  out  1: `rdata_16` holds a burst read word.
- `burst_wdata_req`  out  1: `burst_wdata` is consumed at this edge; the port advances.
- `burst_done`  out  1: equals `ack` for bursts, 0 for singles.
- `rdata_16`  out  16: burst read word.
- `mem_a`  out  ADDR_W: SRAM address.
- `mem_dq_o`  out  16: SRAM write data.
- `mem_dq_i`  in  16: SRAM read data.
- `mem_dq_oe`  out  1: data bus drive enable.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1 each: SRAM strobes, active-low.

## Operation
**FSM states:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, BRD, BWR_SETUP, BWR, DONE.

- **IDLE:** `ready`=1. When `req`=1, latch `addr`, `we`, `wdata` and `burst_len`, then branch:
  - `burst_len`=0 → RD_LO or WR_LO.
  - otherwise → BRD or BWR_SETUP.
- **RD_LO / RD_HI:** drive `addr` / `addr+1` with `mem_ce_n`=`mem_oe_n`=0. Capture `mem_dq_i` into `rdata[15:0]` / `rdata[31:16]` at the end of the state.
- **WR_LO / WR_HI:** drive the address and halfword with `mem_dq_oe`=1 and `mem_we_n`=0 for exactly one cycle each.
- **BRD:**
  - Issue one address per cycle: `addr+i` for i = 0..N-1.
  - Data sampled at the end of issue cycle i appears on `rdata_16` with `burst_data_valid`=1 in the following cycle.
  - After the last issue (or after cancel), wait for the last in-flight word, then go to DONE.
- **BWR_SETUP:** `burst_wdata_req`=1; capture word 0 into `mem_dq_o`. No write strobe.
- **BWR:**
  - Each cycle writes the captured word k to `addr+k` with `mem_we_n`=0.
  - `burst_wdata_req`=1 (capturing word k+1) only while k+1<N and `burst_cancel`=0.
  - After the final word is written → DONE.
- **DONE:** `ack`=1 for one cycle (`burst_done`=1 if the request was a burst), then IDLE.

**Cancel:**
- Sampled only in BRD and BWR.
- BRD: no further addresses are issued; the in-flight word is still delivered.
- BWR: the word on the bus this cycle completes; no further capture.
- Ignored in all other states.
- Words that were not transferred are the port's responsibility to re-request.

**Other rules:**
- Halfword address arithmetic is ADDR_W bits wide and wraps silently.
- `req` arriving during DONE is not accepted until IDLE.

## Timing
- All outputs are registered except `ready`, `burst_wdata_req` and `burst_done`, which decode the current state and inputs.
- Reset values:
  - State = IDLE, so `ready`=1.
  - `ack`, `burst_data_valid`, `burst_wdata_req`, `burst_done` = 0.
  - `rdata` = 0, `rdata_16` = 0, `mem_a` = 0, `mem_dq_o` = 0.
  - `mem_dq_oe` = 0; `mem_ce_n`, `mem_oe_n`, `mem_we_n` = 1.
- Single read or write: `ack` is asserted 3 cycles after the IDLE cycle that sees `req`.
- Burst read of N: first `burst_data_valid` 2 cycles after acceptance; N consecutive valids; `ack` the cycle after the last valid.
- Burst write of N: N `burst_wdata_req` pulses, N `mem_we_n` low cycles, `ack` the cycle after the last write.
- Reset asserted mid-operation: all strobes deassert immediately; no `ack` is generated.

## Configuration
- `SRAM_CTRL_BURST_EN` defined: full behaviour described above.
- `SRAM_CTRL_BURST_EN` not defined:
  - `burst_len`, `burst_wdata` and `burst_cancel` are ignored; every request is single-word.
  - BRD, BWR_SETUP and BWR are not built.
  - `burst_data_valid`, `burst_wdata_req`, `burst_done` and `rdata_16` are tied to 0.

## Test plan
- Reset, then a single write of 0xDEADBEEF to 0x000100 → `mem_a` 0x100 with 0xBEEF, then 0x101 with 0xDEAD, each with `mem_we_n` low 1 cycle; `ack` 3 cycles after acceptance.
- Single read of 0x000100 from the SRAM model → `rdata`=0xDEADBEEF while `ack`=1; `burst_done`=0.
- Burst read, `burst_len`=8 at 0xFFFFFC → addresses 0xFFFFFC..0xFFFFFF then wrap to 0x000000..0x000003; 8 contiguous `burst_data_valid`; one `ack` with `burst_done`.
- Burst write, `burst_len`=4, port supplying 0x1111..0x4444 → 4 `burst_wdata_req` pulses; SRAM holds the words in order; `ack` once.
- Burst read of 16 with `burst_cancel` pulsed in the 5th BRD cycle → exactly 5 `burst_data_valid`, then `ack`; `ready` high the next cycle.
- Reset pulsed during WR_HI → `mem_we_n`=1 and `mem_dq_oe`=0 immediately; no `ack`; `ready`=1 after release.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: arbiter-side responder that turns single-word and burst requests into
// 16-bit asynchronous SRAM cycles. Define SRAM_CTRL_BURST_EN to build the burst engine.
module sram_controller #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [7:0]        burst_len,
  input  logic [15:0]       burst_wdata,
  input  logic              burst_cancel,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              ready,
  output logic              burst_data_valid,
  output logic              burst_wdata_req,
  output logic              burst_done,
  output logic [15:0]       rdata_16,
  output logic [ADDR_W-1:0] mem_a,
  output logic [15:0]       mem_dq_o,
  input  logic [15:0]       mem_dq_i,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, WR_LO, WR_HI,
`ifdef SRAM_CTRL_BURST_EN
    BRD, BWR_SETUP, BWR,
`endif
    DONE
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_hi_q;

`ifdef SRAM_CTRL_BURST_EN
  logic [7:0] len_q;
  logic [7:0] cnt_q;       // addresses issued (read) or words captured (write) so far
  logic       burst_q;
  logic       issue_q;     // current BRD cycle drives a read address
  logic       issue_more;
  logic       take_word;
`endif

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
`ifdef SRAM_CTRL_BURST_EN
    issue_more = 1'b0;
    take_word  = 1'b0;
`endif
    case (state)
      IDLE: if (req) begin
        next_state = we ? WR_LO : RD_LO;
`ifdef SRAM_CTRL_BURST_EN
        if (burst_len != 8'd0) next_state = we ? BWR_SETUP : BRD;
`endif
      end
      RD_LO: next_state = RD_HI;
      RD_HI: next_state = DONE;
      WR_LO: next_state = WR_HI;
      WR_HI: next_state = DONE;
`ifdef SRAM_CTRL_BURST_EN
      BRD: begin
        issue_more = issue_q && (cnt_q < len_q) && !burst_cancel;
        if (!issue_q) next_state = DONE;  // drain cycle delivers the last in-flight word
      end
      BWR_SETUP: begin
        take_word  = 1'b1;
        next_state = BWR;
      end
      BWR: begin
        take_word = (cnt_q < len_q) && !burst_cancel;
        if (!take_word) next_state = DONE;
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  assign ready = (state == IDLE);

`ifdef SRAM_CTRL_BURST_EN
  assign burst_wdata_req = take_word;
  assign burst_done      = ack && burst_q;
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{burst_len, burst_wdata, burst_cancel};
  assign burst_wdata_req  = 1'b0;
  assign burst_done       = 1'b0;
  assign burst_data_valid = 1'b0;
  assign rdata_16         = 16'h0000;
`endif

  // Strobes and bus are registered from the state being entered, so they change on clean edges.
  // NOTE: there is no storage array here, so every register is reset; reset also drops strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q           <= '0;
      wdata_hi_q       <= '0;
      rdata            <= '0;
      ack              <= 1'b0;
      mem_a            <= '0;
      mem_dq_o         <= '0;
      mem_dq_oe        <= 1'b0;
      mem_ce_n         <= 1'b1;
      mem_oe_n         <= 1'b1;
      mem_we_n         <= 1'b1;
`ifdef SRAM_CTRL_BURST_EN
      len_q            <= '0;
      cnt_q            <= '0;
      burst_q          <= 1'b0;
      issue_q          <= 1'b0;
      burst_data_valid <= 1'b0;
      rdata_16         <= '0;
`endif
    end else begin
      ack <= (next_state == DONE);
`ifdef SRAM_CTRL_BURST_EN
      burst_data_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (req) begin
          addr_q     <= addr;
          wdata_hi_q <= wdata[31:16];
          mem_a      <= addr;
`ifdef SRAM_CTRL_BURST_EN
          len_q      <= burst_len;
          burst_q    <= (burst_len != 8'd0);
          cnt_q      <= 8'd0;
`endif
          case (next_state)
            RD_LO: begin
              mem_ce_n <= 1'b0;
              mem_oe_n <= 1'b0;
            end
            WR_LO: begin
              mem_ce_n  <= 1'b0;
              mem_we_n  <= 1'b0;
              mem_dq_oe <= 1'b1;
              mem_dq_o  <= wdata[15:0];
            end
`ifdef SRAM_CTRL_BURST_EN
            BRD: begin
              mem_ce_n <= 1'b0;
              mem_oe_n <= 1'b0;
              issue_q  <= 1'b1;
              cnt_q    <= 8'd1;
            end
`endif
            default: ;
          endcase
        end
        RD_LO: begin
          rdata[15:0] <= mem_dq_i;
          mem_a       <= addr_q + ADDR_W'(1);
        end
        RD_HI: begin
          rdata[31:16] <= mem_dq_i;
          mem_ce_n     <= 1'b1;
          mem_oe_n     <= 1'b1;
        end
        WR_LO: begin
          mem_a    <= addr_q + ADDR_W'(1);
          mem_dq_o <= wdata_hi_q;
        end
        WR_HI: begin
          mem_ce_n  <= 1'b1;
          mem_we_n  <= 1'b1;
          mem_dq_oe <= 1'b0;
        end
`ifdef SRAM_CTRL_BURST_EN
        BRD: begin
          if (issue_q) begin
            rdata_16         <= mem_dq_i;
            burst_data_valid <= 1'b1;
          end
          if (issue_more) begin
            mem_a <= addr_q + ADDR_W'(cnt_q);
            cnt_q <= cnt_q + 8'd1;
          end else begin
            issue_q  <= 1'b0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
          end
        end
        BWR_SETUP, BWR: begin
          if (take_word) begin
            mem_a     <= addr_q + ADDR_W'(cnt_q);
            mem_dq_o  <= burst_wdata;
            cnt_q     <= cnt_q + 8'd1;
            mem_ce_n  <= 1'b0;
            mem_we_n  <= 1'b0;
            mem_dq_oe <= 1'b1;
          end else begin
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_dq_oe <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized bench with a halfword SRAM model and a reference memory
// derived from the address/data rules; burst scenarios run when SRAM_CTRL_BURST_EN is defined.
`timescale 1ns/1ps
module tb_sram_controller;
  localparam int AW = 24;
`ifdef SRAM_CTRL_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, burst_cancel = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [7:0]    burst_len = '0;
  logic [15:0]   burst_wdata = '0;
  logic [31:0]   rdata;
  logic          ack, ready, burst_data_valid, burst_wdata_req, burst_done;
  logic [15:0]   rdata_16, mem_dq_o;
  logic [15:0]   mem_dq_i = '0;
  logic [AW-1:0] mem_a;
  logic          mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n;

  sram_controller #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .burst_len(burst_len), .burst_wdata(burst_wdata), .burst_cancel(burst_cancel),
    .rdata(rdata), .ack(ack), .ready(ready), .burst_data_valid(burst_data_valid),
    .burst_wdata_req(burst_wdata_req), .burst_done(burst_done), .rdata_16(rdata_16),
    .mem_a(mem_a), .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(mem_dq_oe),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram    [logic [AW-1:0]];
  logic [15:0] ref_mem [logic [AW-1:0]];
  int checks = 0;
  int failures = 0;

  // Asynchronous SRAM model, evaluated mid-cycle when the controller's registered pins are stable.
  always @(negedge clk) begin
    if (!mem_ce_n && !mem_we_n && mem_dq_oe) sram[mem_a] = mem_dq_o;
    if (!mem_ce_n && !mem_oe_n) mem_dq_i <= sram.exists(mem_a) ? sram[mem_a] : 16'h0000;
    else                        mem_dq_i <= 16'h0000;
  end

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : 16'h0000;
  endfunction

  task automatic apply_reset();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; burst_len = '0; burst_wdata = '0; burst_cancel = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One single-word request; returns data at ack, ack latency in cycles, write-strobe cycles and burst activity.
  task automatic do_single(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [7:0] bl,
                           output logic [31:0] rd, output int lat, output int we_cyc, output int bseen);
    req = 1'b1; we = w; addr = a; wdata = d; burst_len = bl;
    rd = '0; lat = -1; we_cyc = 0; bseen = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!mem_we_n) we_cyc++;
      if (burst_data_valid || burst_wdata_req || burst_done) bseen++;
      if (ack) begin lat = k; rd = rdata; end
    end
    req = 1'b0; burst_len = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({ready, ack, burst_data_valid, burst_wdata_req, burst_done, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n} !== 9'b100000111) begin
      failures++; $display("FAIL reset_ctrl: got %b want 100000111", {ready, ack, burst_data_valid, burst_wdata_req, burst_done, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n});
    end
    checks++; if ({rdata, rdata_16, mem_a, mem_dq_o} !== '0) begin
      failures++; $display("FAIL reset_data: rdata=%h rdata_16=%h mem_a=%h mem_dq_o=%h want all 0", rdata, rdata_16, mem_a, mem_dq_o);
    end
  endtask

  task automatic test_single_write();
    req = 1'b1; we = 1'b1; addr = 24'h000100; wdata = 32'hDEADBEEF; burst_len = '0;
    @(negedge clk);
    checks++; if ({mem_a, mem_dq_o, mem_we_n, mem_dq_oe, mem_ce_n, ack} !== {24'h000100, 16'hBEEF, 4'b0100}) begin
      failures++; $display("FAIL wr_lo: a=%h d=%h we_n=%b oe=%b ce_n=%b ack=%b want 000100 beef 0 1 0 0", mem_a, mem_dq_o, mem_we_n, mem_dq_oe, mem_ce_n, ack);
    end
    @(negedge clk);
    checks++; if ({mem_a, mem_dq_o, mem_we_n, mem_dq_oe, mem_ce_n, ack} !== {24'h000101, 16'hDEAD, 4'b0100}) begin
      failures++; $display("FAIL wr_hi: a=%h d=%h we_n=%b oe=%b ce_n=%b ack=%b want 000101 dead 0 1 0 0", mem_a, mem_dq_o, mem_we_n, mem_dq_oe, mem_ce_n, ack);
    end
    @(negedge clk);
    checks++; if ({ack, burst_done, mem_we_n, mem_dq_oe, mem_ce_n} !== 5'b10101) begin
      failures++; $display("FAIL wr_ack: ack=%b burst_done=%b we_n=%b oe=%b ce_n=%b want 1 0 1 0 1", ack, burst_done, mem_we_n, mem_dq_oe, mem_ce_n);
    end
    req = 1'b0;
    @(negedge clk);
    checks++; if ({ready, ack} !== 2'b10) begin
      failures++; $display("FAIL wr_after: ready=%b ack=%b want 1 0", ready, ack);
    end
    ref_mem[24'h000100] = 16'hBEEF;
    ref_mem[24'h000101] = 16'hDEAD;
    checks++; if ({sram_rd(24'h000101), sram_rd(24'h000100)} !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_mem: got %h want deadbeef", {sram_rd(24'h000101), sram_rd(24'h000100)});
    end
  endtask

  task automatic test_single_read();
    logic [31:0] rd; int lat, wc, bs;
    do_single(1'b0, 24'h000100, 32'h0, 8'd0, rd, lat, wc, bs);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++; if (bs !== 0) begin failures++; $display("FAIL rd_burst_flags: got %0d active cycles want 0", bs); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rd_ready: got %b want 1", ready); end
  endtask

  task automatic test_random_singles();
    logic [AW-1:0] pool [6];
    logic [31:0] rd, d; logic [7:0] bl; int lat, wc, bs, p; logic w;
    pool[0] = 24'hFFFFFF;
    for (int i = 1; i < 6; i++) pool[i] = AW'($urandom_range(0, 24'h0FFFFF));
    for (int i = 0; i < 36; i++) begin
      p  = (i < 6) ? i : int'($urandom_range(0, 5));
      w  = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      d  = $urandom;
      bl = BURST_BUILD ? 8'd0 : 8'($urandom_range(1, 255));
      do_single(w, pool[p], d, bl, rd, lat, wc, bs);
      checks++; if (lat !== 3 || bs !== 0) begin
        failures++; $display("FAIL rand_timing[%0d]: latency=%0d burst_flags=%0d want 3 0", i, lat, bs);
      end
      if (w) begin
        ref_mem[pool[p]] = d[15:0];
        ref_mem[pool[p] + AW'(1)] = d[31:16];
        checks++; if (wc !== 2) begin failures++; $display("FAIL rand_we_cycles[%0d]: got %0d want 2", i, wc); end
      end else begin
        checks++; if (rd !== {ref_rd(pool[p] + AW'(1)), ref_rd(pool[p])}) begin
          failures++; $display("FAIL rand_read[%0d] @%h: got %h want %h", i, pool[p], rd, {ref_rd(pool[p] + AW'(1)), ref_rd(pool[p])});
        end
      end
    end
  endtask

  task automatic test_memory_image();
    foreach (ref_mem[x]) begin
      checks++; if (sram_rd(x) !== ref_mem[x]) begin
        failures++; $display("FAIL mem_image @%h: got %h want %h", x, sram_rd(x), ref_mem[x]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    req = 1'b1; we = 1'b1; addr = 24'h800000; wdata = $urandom; burst_len = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we_n !== 1'b0) begin failures++; $display("FAIL rst_mid_pre: we_n=%b want 0", mem_we_n); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_we_n, mem_dq_oe, mem_ce_n, mem_oe_n} !== 4'b1011) begin
      failures++; $display("FAIL rst_mid_strobes: we_n=%b oe=%b ce_n=%b oe_n=%b want 1 0 1 1", mem_we_n, mem_dq_oe, mem_ce_n, mem_oe_n);
    end
    req = 1'b0;
    repeat (2) @(negedge clk) if (ack) acks++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk) if (ack) acks++;
    checks++; if (acks !== 0) begin failures++; $display("FAIL rst_mid_ack: got %0d acks want 0", acks); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
  endtask

`ifdef SRAM_CTRL_BURST_EN
  logic [15:0]   q_rd[$];
  logic [AW-1:0] q_addr[$];
  logic [15:0]   bw_words [32];
  int first_v, last_v, ack_cyc, n_ack, bdone_bad, v_gap, pulses, we_lo, last_we;
  logic ready_after;

  task automatic run_burst_read(input logic [AW-1:0] a, input int n, input int cancel_at);
    q_rd.delete(); q_addr.delete();
    first_v = -1; last_v = -1; ack_cyc = -1; n_ack = 0; bdone_bad = 0; v_gap = 0; ready_after = 1'b0;
    req = 1'b1; we = 1'b0; addr = a; burst_len = 8'(n);
    for (int k = 1; k <= n + 20; k++) begin
      @(negedge clk);
      burst_cancel = (k == cancel_at);
      if (!mem_ce_n && !mem_oe_n) q_addr.push_back(mem_a);
      if (burst_data_valid) begin
        if (last_v >= 0 && last_v != k - 1) v_gap++;
        if (first_v < 0) first_v = k;
        last_v = k;
        q_rd.push_back(rdata_16);
      end
      if (ack) begin n_ack++; if (ack_cyc < 0) ack_cyc = k; if (!burst_done) bdone_bad++; req = 1'b0; end
      if (ack_cyc >= 0 && k == ack_cyc + 1) ready_after = ready;
      if (ack_cyc >= 0 && k >= ack_cyc + 2) break;
    end
    burst_cancel = 1'b0; req = 1'b0; burst_len = '0;
  endtask

  task automatic run_burst_write(input logic [AW-1:0] a, input int n, input int cancel_at);
    int idx = 0; logic took = 1'b0;
    pulses = 0; we_lo = 0; last_we = -1; ack_cyc = -1; n_ack = 0; bdone_bad = 0; ready_after = 1'b0;
    req = 1'b1; we = 1'b1; addr = a; burst_len = 8'(n); burst_wdata = bw_words[0];
    for (int k = 1; k <= n + 20; k++) begin
      @(negedge clk);
      if (took) idx++;
      burst_wdata = (idx < 32) ? bw_words[idx] : 16'h0000;
      burst_cancel = (k == cancel_at);
      #1;
      took = burst_wdata_req;
      if (took) pulses++;
      if (!mem_we_n) begin we_lo++; last_we = k; end
      if (ack) begin n_ack++; if (ack_cyc < 0) ack_cyc = k; if (!burst_done) bdone_bad++; req = 1'b0; end
      if (ack_cyc >= 0 && k == ack_cyc + 1) ready_after = ready;
      if (ack_cyc >= 0 && k >= ack_cyc + 2) break;
    end
    burst_cancel = 1'b0; req = 1'b0; burst_len = '0;
  endtask

  // Checks a finished burst read against m expected words starting at a.
  task automatic check_burst_read(input string tag, input logic [AW-1:0] a, input int m);
    checks++; if (q_rd.size() !== m || q_addr.size() !== m) begin
      failures++; $display("FAIL %s_count: valids=%0d addrs=%0d want %0d", tag, q_rd.size(), q_addr.size(), m);
    end
    for (int i = 0; i < m && i < q_rd.size() && i < q_addr.size(); i++) begin
      checks++; if (q_addr[i] !== a + AW'(i) || q_rd[i] !== ref_rd(a + AW'(i))) begin
        failures++; $display("FAIL %s_word[%0d]: addr=%h data=%h want %h %h", tag, i, q_addr[i], q_rd[i], a + AW'(i), ref_rd(a + AW'(i)));
      end
    end
    checks++; if (first_v !== 2 || v_gap !== 0) begin
      failures++; $display("FAIL %s_valid_timing: first=%0d gaps=%0d want 2 0", tag, first_v, v_gap);
    end
    checks++; if (n_ack !== 1 || ack_cyc !== last_v + 1 || bdone_bad !== 0 || ready_after !== 1'b1) begin
      failures++; $display("FAIL %s_ack: acks=%0d at=%0d last_valid=%0d bdone_bad=%0d ready_after=%b want 1 last+1 0 1", tag, n_ack, ack_cyc, last_v, bdone_bad, ready_after);
    end
  endtask

  // Checks a finished burst write that should have written m words, and folds them into the reference.
  task automatic check_burst_write(input string tag, input logic [AW-1:0] a, input int m);
    for (int i = 0; i < m; i++) ref_mem[a + AW'(i)] = bw_words[i];
    checks++; if (pulses !== m || we_lo !== m) begin
      failures++; $display("FAIL %s_count: wdata_req=%0d we_low=%0d want %0d", tag, pulses, we_lo, m);
    end
    checks++; if (n_ack !== 1 || ack_cyc !== last_we + 1 || ack_cyc !== m + 2 || bdone_bad !== 0) begin
      failures++; $display("FAIL %s_ack: acks=%0d at=%0d last_we=%0d bdone_bad=%0d want 1 at %0d", tag, n_ack, ack_cyc, last_we, bdone_bad, m + 2);
    end
    for (int i = 0; i <= m; i++) begin
      checks++; if (sram_rd(a + AW'(i)) !== ref_rd(a + AW'(i))) begin
        failures++; $display("FAIL %s_mem[%0d]: got %h want %h", tag, i, sram_rd(a + AW'(i)), ref_rd(a + AW'(i)));
      end
    end
  endtask

  task automatic test_burst_read();
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      sram[24'hFFFFFC + AW'(i)] = v;
      ref_mem[24'hFFFFFC + AW'(i)] = v;
    end
    run_burst_read(24'hFFFFFC, 8, 0);
    check_burst_read("bread_wrap", 24'hFFFFFC, 8);
  endtask

  task automatic test_burst_write();
    int n; logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) bw_words[i] = 16'h1111 * 16'(i + 1);
    run_burst_write(24'h000200, 4, 0);
    check_burst_write("bwrite", 24'h000200, 4);
    n = $urandom_range(1, 20);
    a = 24'hFFFFF0 + AW'($urandom_range(0, 15));
    for (int i = 0; i < 32; i++) bw_words[i] = 16'($urandom);
    run_burst_write(a, n, 0);
    check_burst_write("bwrite_rand", a, n);
    run_burst_read(a, n, 0);
    check_burst_read("bread_back", a, n);
  endtask

  task automatic test_burst_cancel();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      sram[24'h300000 + AW'(i)] = v;
      ref_mem[24'h300000 + AW'(i)] = v;
    end
    run_burst_read(24'h300000, 16, 5);
    check_burst_read("bread_cancel", 24'h300000, 5);
    for (int i = 0; i < 32; i++) bw_words[i] = 16'($urandom);
    run_burst_write(24'h310000, 8, 4);
    check_burst_write("bwrite_cancel", 24'h310000, 3);
  endtask
`else
  task automatic test_burst_ignored();
    logic [31:0] rd; int lat, wc, bs;
    do_single(1'b0, 24'h000100, 32'h0, 8'd8, rd, lat, wc, bs);
    checks++; if (rd !== 32'hDEADBEEF || lat !== 3) begin
      failures++; $display("FAIL burst_ignored_read: data=%h latency=%0d want deadbeef 3", rd, lat);
    end
    checks++; if (bs !== 0 || rdata_16 !== 16'h0000) begin
      failures++; $display("FAIL burst_ignored_flags: active=%0d rdata_16=%h want 0 0000", bs, rdata_16);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
`ifdef SRAM_CTRL_BURST_EN
    test_burst_read();
    test_burst_write();
    test_burst_cancel();
`else
    test_burst_ignored();
`endif
    test_random_singles();
    test_memory_image();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
